// File: rtl/online_otf_converter.sv
`default_nettype none
// ============================================================================
//  Module      : online_otf_converter
//  Description : On-the-fly Q/QM conversion of an MSD-first signed-digit
//                stream into PRECISION+1 bit two's-complement words.
//  Revision    : 1.0 - initial release
// ============================================================================
module online_otf_converter #(
  parameter int PRECISION = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           digit_in,
  input  logic                 digit_valid,
  input  logic                 flush,
  output logic [PRECISION:0]   result,
  output logic                 result_valid,
  output logic                 digit_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(PRECISION + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(PRECISION - 1);
  localparam logic [PRECISION:0] C_Q_INIT  = '0;
  localparam logic [PRECISION:0] C_QM_INIT = '1;

  logic [PRECISION:0] r_q;
  logic [PRECISION:0] r_qm;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err_acc;
  logic [PRECISION:0] r_result;
  logic               r_result_valid;
  logic               r_digit_err;

  logic               w_pos;
  logic               w_neg;
  logic               w_rsv;
  logic [PRECISION:0] w_q_nxt;
  logic [PRECISION:0] w_qm_nxt;
  logic               w_last;

  assign w_pos  = (digit_in == 2'b01);
  assign w_neg  = (digit_in == 2'b11);
  assign w_rsv  = (digit_in == 2'b10);
  assign w_last = (r_cnt == C_LAST);

  // QM tracks Q-1 so a negative digit never needs a borrow chain.
  always_comb begin
    w_q_nxt  = {r_q[PRECISION-1:0], 1'b0};
    w_qm_nxt = {r_qm[PRECISION-1:0], 1'b1};
    if (w_pos) begin
      w_q_nxt  = {r_q[PRECISION-1:0], 1'b1};
      w_qm_nxt = {r_q[PRECISION-1:0], 1'b0};
    end else if (w_neg) begin
      w_q_nxt  = {r_qm[PRECISION-1:0], 1'b1};
      w_qm_nxt = {r_qm[PRECISION-1:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q            <= C_Q_INIT;
      r_qm           <= C_QM_INIT;
      r_cnt          <= '0;
      r_err_acc      <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_digit_err    <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      if (flush) begin
        r_q       <= C_Q_INIT;
        r_qm      <= C_QM_INIT;
        r_cnt     <= '0;
        r_err_acc <= 1'b0;
      end else if (digit_valid) begin
        if (w_last) begin
          // Final digit: publish and restart in the same edge, no bubble.
          r_result       <= w_q_nxt;
          r_digit_err    <= r_err_acc | w_rsv;
          r_result_valid <= 1'b1;
          r_q            <= C_Q_INIT;
          r_qm           <= C_QM_INIT;
          r_cnt          <= '0;
          r_err_acc      <= 1'b0;
        end else begin
          r_q       <= w_q_nxt;
          r_qm      <= w_qm_nxt;
          r_cnt     <= r_cnt + 1'b1;
          r_err_acc <= r_err_acc | w_rsv;
        end
      end
    end
  end

  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign digit_err    = r_digit_err;
  assign busy         = (r_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_online_otf_converter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_online_otf_converter
//  Description : Scoreboard bench for online_otf_converter, PRECISION=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_online_otf_converter;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   digit_in;
  logic         digit_valid;
  logic         flush;
  logic [N:0]   result;
  logic         result_valid;
  logic         digit_err;
  logic         busy;

  typedef struct packed {
    logic [N:0] r;
    logic       e;
  } exp_t;

  exp_t exp_q[$];
  int   strobe_cyc[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_push = 0;

  localparam logic [1:0] P = 2'b01;
  localparam logic [1:0] Z = 2'b00;
  localparam logic [1:0] M = 2'b11;
  localparam logic [1:0] R = 2'b10;

  online_otf_converter #(.PRECISION(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .digit_in     (digit_in),
    .digit_valid  (digit_valid),
    .flush        (flush),
    .result       (result),
    .result_valid (result_valid),
    .digit_err    (digit_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && result_valid) begin
      strobe_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 32'(result), 32'h1ff_ffff);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", 32'(result), 32'(e.r));
        chk("digit_err", 32'(digit_err), 32'(e.e));
      end
    end
  end

  task automatic step(input logic v, input logic [1:0] d, input logic f);
    digit_valid = v;
    digit_in    = d;
    flush       = f;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, Z, 1'b0);
  endtask

  task automatic expect_word(input logic [N:0] r, input logic e);
    exp_t x;
    x.r = r;
    x.e = e;
    exp_q.push_back(x);
    n_push++;
  endtask

  // Expectation is queued just before the final digit so an early strobe
  // finds an empty queue.
  task automatic word(input logic [1:0] ds [N], input logic [N:0] r,
                      input logic e, input bit gap);
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) expect_word(r, e);
      step(1'b1, ds[i], 1'b0);
      if (gap) step(1'b0, Z, 1'b0);
    end
  endtask

  function automatic logic [N:0] ref_val(input logic [1:0] ds [N]);
    int s;
    s = 0;
    for (int i = 0; i < N; i++) begin
      if (ds[i] == P) s += (1 << (N - 1 - i));
      else if (ds[i] == M) s -= (1 << (N - 1 - i));
    end
    return (N+1)'(s);
  endfunction

  logic [1:0] w_a   [N] = '{P, Z, Z, Z, Z, Z, Z, Z};
  logic [1:0] w_b   [N] = '{M, P, Z, Z, Z, Z, Z, Z};
  logic [1:0] w_m   [N] = '{M, M, M, M, M, M, M, M};
  logic [1:0] w_p   [N] = '{P, P, P, P, P, P, P, P};
  logic [1:0] w_e   [N] = '{P, P, R, Z, Z, Z, Z, Z};
  logic [1:0] w_r   [N];

  initial begin
    int base;
    int rnd_err;
    rst = 1'b1; digit_in = Z; digit_valid = 1'b0; flush = 1'b0;
    #23;
    chk("rst_result", 32'(result), 0);
    chk("rst_valid", 32'(result_valid), 0);
    chk("rst_err", 32'(digit_err), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk); #1 rst = 1'b0;
    idle(2);
    chk("idle_valid", 32'(result_valid), 0);

    word(w_a, 9'h080, 1'b0, 1'b0);
    word(w_b, 9'h1C0, 1'b0, 1'b0);
    word(w_m, 9'h101, 1'b0, 1'b0);
    word(w_p, 9'h0FF, 1'b0, 1'b0);
    idle(3);

    // Back-to-back words: strobes exactly N cycles apart.
    base = strobe_cyc.size();
    word(w_p, 9'h0FF, 1'b0, 1'b0);
    word(w_m, 9'h101, 1'b0, 1'b0);
    idle(3);
    chk("b2b_count", 32'(strobe_cyc.size()), 32'(base + 2));
    if (strobe_cyc.size() == base + 2)
      chk("b2b_spacing", 32'(strobe_cyc[base+1] - strobe_cyc[base]), 8);

    word(w_b, 9'h1C0, 1'b0, 1'b1);
    idle(2);

    // Flush after five digits, then a clean word.
    for (int i = 0; i < 5; i++) step(1'b1, P, 1'b0);
    chk("busy_mid", 32'(busy), 1);
    step(1'b0, Z, 1'b1);
    chk("busy_after_flush", 32'(busy), 0);
    word(w_a, 9'h080, 1'b0, 1'b0);
    idle(2);

    // Flush together with the would-be final digit.
    for (int i = 0; i < N - 1; i++) step(1'b1, M, 1'b0);
    step(1'b1, P, 1'b1);
    idle(3);
    chk("flush8_result_hold", 32'(result), 32'h080);
    chk("flush8_busy", 32'(busy), 0);

    word(w_e, 9'h0C0, 1'b1, 1'b0);
    idle(2);
    chk("err_hold", 32'(digit_err), 1);
    word(w_a, 9'h080, 1'b0, 1'b0);
    idle(2);

    // Reset mid-word.
    for (int i = 0; i < 4; i++) step(1'b1, P, 1'b0);
    digit_valid = 1'b0;
    rst = 1'b1;
    #2;
    chk("midrst_result", 32'(result), 0);
    chk("midrst_err", 32'(digit_err), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_valid", 32'(result_valid), 0);
    @(posedge clk); #1 rst = 1'b0;
    idle(3);
    word(w_p, 9'h0FF, 1'b0, 1'b0);
    idle(2);

    for (int k = 0; k < 1000; k++) begin
      rnd_err = 0;
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 7))
          0, 1, 2: w_r[i] = P;
          3, 4, 5: w_r[i] = M;
          6:       w_r[i] = Z;
          default: begin w_r[i] = R; rnd_err = 1; end
        endcase
      end
      word(w_r, ref_val(w_r), rnd_err[0], 1'b0);
    end
    idle(4);

    chk("pending_expectations", 32'(exp_q.size()), 0);
    chk("strobe_total", 32'(strobe_cyc.size()), 32'(n_push));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
